// File: rtl/conv3x3_sequencer_if.sv
// Stream-in, MAC-issue and result signals of the 3x3 convolution sequencer.
// The master side is the environment that feeds data and hosts the MAC; the sequencer is the slave.
interface conv3x3_sequencer_if;
  logic        in_valid;
  logic        weight_valid;
  logic [15:0] In_IFM_1;
  logic [15:0] In_Weight_1;
  logic        mac_en;
  logic        mac_clr;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic [35:0] mac_acc;
  logic        busy;
  logic        out_valid;
  logic [35:0] Out_OFM;

  modport master (
    output in_valid, weight_valid, In_IFM_1, In_Weight_1, mac_acc,
    input  mac_en, mac_clr, mac_a, mac_b, busy, out_valid, Out_OFM
  );

  modport slave (
    input  in_valid, weight_valid, In_IFM_1, In_Weight_1, mac_acc,
    output mac_en, mac_clr, mac_a, mac_b, busy, out_valid, Out_OFM
  );
endinterface

// File: rtl/conv3x3_sequencer.sv
// Buffers an IFM_W x IFM_W map and 9 weights, then drives an external MAC one tap per cycle.
// First issue one cycle after both buffers fill; each result appears one cycle after its k=8 tap; no input backpressure.
module conv3x3_sequencer #(
  parameter int IFM_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  conv3x3_sequencer_if.slave   bus
);

  localparam int OFM_W = IFM_W - 2;
  localparam int IFM_N = IFM_W * IFM_W;
  localparam int CW    = $clog2(IFM_N + 1);
  localparam int IW    = $clog2(IFM_N);
  localparam int PW    = $clog2(IFM_W);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    FLUSH
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [15:0]     ifm_buf [IFM_N];
  logic [15:0]     w_buf   [9];

  logic [CW-1:0]   ifm_cnt;
  logic [3:0]      w_cnt;
  logic [PW-1:0]   r_q;
  logic [PW-1:0]   c_q;
  logic [1:0]      kr_q;
  logic [1:0]      kc_q;
  logic            out_vld_q;

  logic            loading;
  logic            computing;
  logic            ifm_we;
  logic            w_we;
  logic            ifm_full_d;
  logic            w_full_d;
  logic            k_last;
  logic            pix_last;
  logic [IW-1:0]   ifm_idx;
  logic [3:0]      w_idx;

  assign loading   = (state_q == IDLE) || (state_q == LOAD);
  assign computing = (state_q == COMPUTE);

  // Words past the buffer depth are dropped rather than wrapping over index 0.
  assign ifm_we = loading && bus.in_valid     && (ifm_cnt < CW'(IFM_N));
  assign w_we   = loading && bus.weight_valid && (w_cnt < 4'd9);

  // "Full after this edge" lets the last write and the move to COMPUTE share a cycle.
  assign ifm_full_d = (ifm_cnt == CW'(IFM_N)) || (ifm_we && (ifm_cnt == CW'(IFM_N - 1)));
  assign w_full_d   = (w_cnt == 4'd9) || (w_we && (w_cnt == 4'd8));

  assign k_last   = (kr_q == 2'd2) && (kc_q == 2'd2);
  assign pix_last = (r_q == PW'(OFM_W - 1)) && (c_q == PW'(OFM_W - 1));

  assign ifm_idx = IW'((int'(r_q) + int'(kr_q)) * IFM_W + int'(c_q) + int'(kc_q));
  assign w_idx   = ({2'b00, kr_q} * 4'd3) + {2'b00, kc_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid || bus.weight_valid) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (ifm_full_d && w_full_d) begin
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        if (k_last && pix_last) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Issue outputs decode straight from registered state so the MAC sees them in the cycle they belong to.
  always_comb begin
    bus.mac_en    = 1'b0;
    bus.mac_clr   = 1'b0;
    bus.mac_a     = 16'h0000;
    bus.mac_b     = 16'h0000;
    bus.busy      = (state_q != IDLE);
    bus.out_valid = out_vld_q;
    bus.Out_OFM   = 36'd0;
    if (computing) begin
      bus.mac_en  = 1'b1;
      bus.mac_clr = (kr_q == 2'd0) && (kc_q == 2'd0);
      bus.mac_a   = ifm_buf[ifm_idx];
      bus.mac_b   = w_buf[w_idx];
    end
    if (out_vld_q) begin
      bus.Out_OFM = bus.mac_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ifm_cnt   <= '0;
      w_cnt     <= 4'd0;
      r_q       <= '0;
      c_q       <= '0;
      kr_q      <= 2'd0;
      kc_q      <= 2'd0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_vld_q <= computing && k_last;

      if (ifm_we) begin
        ifm_cnt <= ifm_cnt + CW'(1);
      end
      if (w_we) begin
        w_cnt <= w_cnt + 4'd1;
      end
      if (state_q == FLUSH) begin
        ifm_cnt <= '0;
        w_cnt   <= 4'd0;
      end

      // Tap counter (kr,kc) nested inside the pixel counter (r,c); all wrap to 0 after the last pixel.
      if (computing) begin
        if (kc_q == 2'd2) begin
          kc_q <= 2'd0;
          if (kr_q == 2'd2) begin
            kr_q <= 2'd0;
            if (c_q == PW'(OFM_W - 1)) begin
              c_q <= '0;
              if (r_q == PW'(OFM_W - 1)) begin
                r_q <= '0;
              end else begin
                r_q <= r_q + PW'(1);
              end
            end else begin
              c_q <= c_q + PW'(1);
            end
          end else begin
            kr_q <= kr_q + 2'd1;
          end
        end else begin
          kc_q <= kc_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ifm_we) begin
      ifm_buf[ifm_cnt[IW-1:0]] <= bus.In_IFM_1;
    end
    if (w_we) begin
      w_buf[w_idx_wr()] <= bus.In_Weight_1;
    end
  end

  function automatic logic [3:0] w_idx_wr();
    return w_cnt;
  endfunction

endmodule

// File: tb/tb_conv3x3_sequencer.sv
// Scoreboarded bench for conv3x3_sequencer with a behavioural MAC closing the loop on mac_acc.
module tb_conv3x3_sequencer;

  localparam int IFM_W = 6;
  localparam int OFM_W = IFM_W - 2;
  localparam int N     = IFM_W * IFM_W;
  localparam int NP    = OFM_W * OFM_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv3x3_sequencer_if bus();

  conv3x3_sequencer #(.IFM_W(IFM_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  logic [35:0] sb[$];
  logic [15:0] ifm_m [N];
  logic [15:0] w_m   [9];
  logic [35:0] center_t [NP] = '{36'd7, 36'd8, 36'd9, 36'd10, 36'd13, 36'd14, 36'd15, 36'd16,
                                 36'd19, 36'd20, 36'd21, 36'd22, 36'd25, 36'd26, 36'd27, 36'd28};

  // External MAC: registered accumulator, load on clr, add otherwise.
  always @(posedge clk) begin
    if (rst) begin
      bus.mac_acc <= 36'd0;
    end else if (bus.mac_en) begin
      if (bus.mac_clr) bus.mac_acc <= 36'(bus.mac_a) * 36'(bus.mac_b);
      else             bus.mac_acc <= bus.mac_acc + 36'(bus.mac_a) * 36'(bus.mac_b);
    end
  end

  always @(negedge clk) begin
    if (bus.out_valid) begin
      logic [35:0] exp_v;
      pulses++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid: Out_OFM=%0d, required no pulse", bus.Out_OFM);
      end else begin
        exp_v = sb.pop_front();
        if (bus.Out_OFM !== exp_v) begin
          errors++;
          $display("FAIL ofm_value: got %0d, expected %0d", bus.Out_OFM, exp_v);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.in_valid     = 1'b0;
    bus.weight_valid = 1'b0;
    bus.In_IFM_1     = 16'h0000;
    bus.In_Weight_1  = 16'h0000;
  endtask

  function automatic logic [35:0] conv_px(input int r, input int c);
    logic [35:0] s = 36'd0;
    for (int kr = 0; kr < 3; kr++)
      for (int kc = 0; kc < 3; kc++)
        s += 36'(ifm_m[(r + kr) * IFM_W + c + kc]) * 36'(w_m[kr * 3 + kc]);
    return s;
  endfunction

  task automatic push_model();
    for (int r = 0; r < OFM_W; r++)
      for (int c = 0; c < OFM_W; c++)
        sb.push_back(conv_px(r, c));
  endtask

  // Returns at the negedge just after the edge that accepted the last IFM word.
  task automatic load_std();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      bus.in_valid     = 1'b1;
      bus.In_IFM_1     = ifm_m[i];
      bus.weight_valid = (i < 9);
      bus.In_Weight_1  = (i < 9) ? w_m[i] : 16'h0000;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b, expected 0", bus.busy); end
    checks++; if (bus.mac_en !== 1'b0)   begin errors++; $display("FAIL reset_mac_en: got %b, expected 0", bus.mac_en); end
    checks++; if (bus.mac_clr !== 1'b0)  begin errors++; $display("FAIL reset_mac_clr: got %b, expected 0", bus.mac_clr); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
    checks++; if ({bus.mac_a, bus.mac_b} !== 32'h0) begin errors++; $display("FAIL reset_operands: got %h, expected 0", {bus.mac_a, bus.mac_b}); end
    checks++; if (bus.Out_OFM !== 36'd0) begin errors++; $display("FAIL reset_ofm: got %0d, expected 0", bus.Out_OFM); end
    rst = 1'b0;
  endtask

  task automatic test_all_ones();
    bit ok;
    for (int i = 0; i < N; i++) ifm_m[i] = 16'd1;
    for (int i = 0; i < 9; i++) w_m[i] = 16'd1;
    pulses = 0;
    for (int i = 0; i < NP; i++) sb.push_back(36'd9);
    load_std();
    wait_done(400, ok);
    checks++; if (ok !== 1'b1)   begin errors++; $display("FAIL ones_done: busy still %b, expected 0", bus.busy); end
    checks++; if (pulses !== NP) begin errors++; $display("FAIL ones_pulses: got %0d, expected %0d", pulses, NP); end
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL ones_leftover: got %0d, expected 0", sb.size()); end
  endtask

  task automatic set_center();
    for (int i = 0; i < N; i++) ifm_m[i] = 16'(i);
    for (int i = 0; i < 9; i++) w_m[i] = (i == 4) ? 16'd1 : 16'd0;
  endtask

  task automatic test_center_tap();
    bit ok;
    set_center();
    pulses = 0;
    for (int i = 0; i < NP; i++) sb.push_back(center_t[i]);
    load_std();
    wait_done(400, ok);
    checks++; if (ok !== 1'b1)   begin errors++; $display("FAIL center_done: busy still %b, expected 0", bus.busy); end
    checks++; if (pulses !== NP) begin errors++; $display("FAIL center_pulses: got %0d, expected %0d", pulses, NP); end
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL center_leftover: got %0d, expected 0", sb.size()); end
  endtask

  task automatic test_max();
    bit ok;
    for (int i = 0; i < N; i++) ifm_m[i] = 16'hFFFF;
    for (int i = 0; i < 9; i++) w_m[i] = 16'hFFFF;
    pulses = 0;
    for (int i = 0; i < NP; i++) sb.push_back(36'd38653526025);
    load_std();
    wait_done(400, ok);
    checks++; if (ok !== 1'b1)   begin errors++; $display("FAIL max_done: busy still %b, expected 0", bus.busy); end
    checks++; if (pulses !== NP) begin errors++; $display("FAIL max_pulses: got %0d, expected %0d", pulses, NP); end
  endtask

  task automatic test_timing();
    int first_en = -1, first_ov = -1, last_ov = -1, busy_fall = -1;
    int en_cnt = 0, clr_cnt = 0, clr_bad = 0, zero_bad = 0;
    for (int i = 0; i < N; i++) ifm_m[i] = 16'($urandom_range(0, 65535));
    for (int i = 0; i < 9; i++) w_m[i] = 16'($urandom_range(0, 65535));
    pulses = 0;
    push_model();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.weight_valid = 1'b1;
      bus.In_Weight_1  = w_m[i];
    end
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.In_IFM_1 = ifm_m[i];
    end
    // n indexes the edge T+n that follows each observation; T accepted the last IFM word.
    for (int n = 1; n <= 170; n++) begin
      @(negedge clk);
      if (n == 1) idle_inputs();
      if (bus.mac_en) begin
        en_cnt++;
        if (first_en < 0) first_en = n;
        if (bus.mac_clr) clr_cnt++;
        if (bus.mac_clr !== (((n - 1) % 9) == 0)) clr_bad++;
      end else if (bus.mac_clr !== 1'b0 || bus.mac_a !== 16'h0 || bus.mac_b !== 16'h0) begin
        zero_bad++;
      end
      if (bus.out_valid) begin
        if (first_ov < 0) first_ov = n;
        last_ov = n;
      end else if (bus.Out_OFM !== 36'd0) begin
        zero_bad++;
      end
      if (!bus.busy && busy_fall < 0) busy_fall = n;
    end
    checks++; if (first_en !== 1)    begin errors++; $display("FAIL timing_first_mac_en: got T+%0d, expected T+1", first_en); end
    checks++; if (first_ov !== 10)   begin errors++; $display("FAIL timing_first_out_valid: got T+%0d, expected T+10", first_ov); end
    checks++; if (last_ov !== 145)   begin errors++; $display("FAIL timing_last_out_valid: got T+%0d, expected T+145", last_ov); end
    checks++; if (busy_fall !== 146) begin errors++; $display("FAIL timing_busy_fall: got T+%0d, expected T+146", busy_fall); end
    checks++; if (en_cnt !== 9 * NP) begin errors++; $display("FAIL timing_mac_en_count: got %0d, expected %0d", en_cnt, 9 * NP); end
    checks++; if (clr_cnt !== NP || clr_bad !== 0) begin errors++; $display("FAIL timing_mac_clr: got %0d pulses %0d misplaced, expected %0d and 0", clr_cnt, clr_bad, NP); end
    checks++; if (zero_bad !== 0)    begin errors++; $display("FAIL timing_idle_zero: got %0d nonzero cycles, expected 0", zero_bad); end
    checks++; if (pulses !== NP)     begin errors++; $display("FAIL timing_pulses: got %0d, expected %0d", pulses, NP); end
  endtask

  task automatic test_extras();
    bit ok = 1'b0;
    for (int i = 0; i < N; i++) ifm_m[i] = 16'd1;
    for (int i = 0; i < 9; i++) w_m[i] = 16'd1;
    pulses = 0;
    push_model();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i > 40 && !bus.busy) begin
        ok = 1'b1;
        break;
      end
      bus.in_valid     = 1'b1;
      bus.In_IFM_1     = (i < N) ? ifm_m[i] : 16'hFFFF;
      bus.weight_valid = (i < 12);
      bus.In_Weight_1  = (i < 9) ? w_m[i] : 16'hFFFF;
    end
    idle_inputs();
    checks++; if (ok !== 1'b1)   begin errors++; $display("FAIL extras_done: busy still %b, expected 0", bus.busy); end
    checks++; if (pulses !== NP) begin errors++; $display("FAIL extras_pulses: got %0d, expected %0d", pulses, NP); end
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL extras_leftover: got %0d, expected 0", sb.size()); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort();
    bit ok;
    set_center();
    pulses = 0;
    for (int i = 0; i < 5; i++) sb.push_back(center_t[i]);
    load_std();
    for (int n = 2; n <= 50; n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({bus.busy, bus.mac_en, bus.mac_clr, bus.out_valid} !== 4'b0000) begin errors++; $display("FAIL abort_flags: got %b, expected 0000", {bus.busy, bus.mac_en, bus.mac_clr, bus.out_valid}); end
    checks++; if ({bus.mac_a, bus.mac_b, bus.Out_OFM} !== 68'd0) begin errors++; $display("FAIL abort_data: got %h, expected 0", {bus.mac_a, bus.mac_b, bus.Out_OFM}); end
    repeat (200) @(negedge clk);
    checks++; if (pulses !== 5) begin errors++; $display("FAIL abort_pulses: got %0d, expected 5", pulses); end
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL abort_leftover: got %0d, expected 0", sb.size()); end
    pulses = 0;
    for (int i = 0; i < NP; i++) sb.push_back(center_t[i]);
    load_std();
    wait_done(400, ok);
    checks++; if (ok !== 1'b1)   begin errors++; $display("FAIL reload_done: busy still %b, expected 0", bus.busy); end
    checks++; if (pulses !== NP) begin errors++; $display("FAIL reload_pulses: got %0d, expected %0d", pulses, NP); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_all_ones();
    test_center_tap();
    test_max();
    test_timing();
    test_extras();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
